// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one 128-bit line memory port between a read-only instruction cache
// and a read/write data cache. One client is granted per transaction. Priority
// alternates under contention. Completed transactions are counted per client.
// A watchdog releases any grant that waits too long for the memory.
//
// Parameters
//   TIMEOUT : cycles a grant may wait for mem_ready before forced release
//   CNT_W   : width of the per-client completed-transaction counters
//
// Ports
//   clk, proc_reset            : clock, synchronous active-high reset
//   i_mem_read/addr            : icache request (read only)
//   i_mem_rdata/ready          : icache response
//   d_mem_read/write/addr/wdata: dcache request
//   d_mem_rdata/ready          : dcache response
//   mem_read/write/addr/wdata  : request to memory
//   mem_rdata/ready            : response from memory
//   arb_timeout                : sticky flag, some grant hit TIMEOUT
//   i_txn_cnt, d_txn_cnt       : completed transactions per client
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             proc_reset,
  input  logic             i_mem_read,
  input  logic [27:0]      i_mem_addr,
  output logic [127:0]     i_mem_rdata,
  output logic             i_mem_ready,
  input  logic             d_mem_read,
  input  logic             d_mem_write,
  input  logic [27:0]      d_mem_addr,
  input  logic [127:0]     d_mem_wdata,
  output logic [127:0]     d_mem_rdata,
  output logic             d_mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic [27:0]      mem_addr,
  output logic [127:0]     mem_wdata,
  input  logic [127:0]     mem_rdata,
  input  logic             mem_ready,
  output logic             arb_timeout,
  output logic [CNT_W-1:0] i_txn_cnt,
  output logic [CNT_W-1:0] d_txn_cnt
);

  // Watchdog must be able to hold TIMEOUT-1.
  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_TOP = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2,
    REL   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             lastGrantD_q, lastGrantD_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;
  logic [CNT_W-1:0] iCnt_q, iCnt_d;
  logic [CNT_W-1:0] dCnt_q, dCnt_d;
  logic             timeout_q, timeout_d;

  logic iReq;
  logic dReq;

  assign iReq = i_mem_read;
  assign dReq = d_mem_read | d_mem_write;

  // Next-state logic. Under contention the client that did not complete the
  // last transaction wins. Only a completed transaction moves last_grant,
  // so aborts and timeouts leave the priority unchanged.
  always_comb begin
    state_d      = state_q;
    lastGrantD_d = lastGrantD_q;
    wdog_d       = wdog_q;
    iCnt_d       = iCnt_q;
    dCnt_d       = dCnt_q;
    timeout_d    = timeout_q;
    unique case (state_q)
      IDLE: begin
        // Every grant is entered from IDLE, so the watchdog is cleared here.
        wdog_d = '0;
        if (iReq && (!dReq || lastGrantD_q)) begin
          state_d = GNT_I;
        end else if (dReq) begin
          state_d = GNT_D;
        end
      end
      GNT_I: begin
        if (mem_ready) begin
          lastGrantD_d = 1'b0;
          iCnt_d       = iCnt_q + CNT_W'(1);
          state_d      = REL;
        end else if (!iReq) begin
          state_d = REL;
        end else if (wdog_q == WD_TOP) begin
          timeout_d = 1'b1;
          state_d   = REL;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      GNT_D: begin
        if (mem_ready) begin
          lastGrantD_d = 1'b1;
          dCnt_d       = dCnt_q + CNT_W'(1);
          state_d      = REL;
        end else if (!dReq) begin
          state_d = REL;
        end else if (wdog_q == WD_TOP) begin
          timeout_d = 1'b1;
          state_d   = REL;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      REL: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers. Reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q      <= IDLE;
      lastGrantD_q <= 1'b1;
      wdog_q       <= '0;
      iCnt_q       <= '0;
      dCnt_q       <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      lastGrantD_q <= lastGrantD_d;
      wdog_q       <= wdog_d;
      iCnt_q       <= iCnt_d;
      dCnt_q       <= dCnt_d;
      timeout_q    <= timeout_d;
    end
  end

  // Memory-side mux. The request follows the granted client live, so a client
  // dropping its request is seen by the memory in the same cycle. When both
  // read and write come from the dcache, the write wins.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      GNT_I: begin
        mem_read = i_mem_read;
        mem_addr = i_mem_addr;
      end
      GNT_D: begin
        mem_read  = d_mem_read & ~d_mem_write;
        mem_write = d_mem_write;
        mem_addr  = d_mem_addr;
        mem_wdata = d_mem_wdata;
      end
      default: begin
      end
    endcase
  end

  // Ready is steered to the granted client only. A stray pulse outside a
  // grant reaches neither client.
  assign i_mem_ready = mem_ready & (state_q == GNT_I);
  assign d_mem_ready = mem_ready & (state_q == GNT_D);
  assign i_mem_rdata = mem_rdata;
  assign d_mem_rdata = mem_rdata;

  assign arb_timeout = timeout_q;
  assign i_txn_cnt   = iCnt_q;
  assign d_txn_cnt   = dCnt_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single 128-bit line memory port between an instruction cache (read-only) and a data cache (read/write).
- Both clients use the same level handshake as the memory:
  - the client holds mem_read or mem_write plus the address until mem_ready pulses for one cycle;
  - the client drops the request on the following cycle.
- The arbiter grants one client per transaction, alternates priority under contention, counts completed transactions and flags hung transactions.

Parameters:
TIMEOUT, 1024, cycles a granted transaction may wait for mem_ready before forced release
CNT_W, 16, width of per-client transaction counters

Ports:
clk  input  1  clock; all state updates on rising edge
proc_reset  input  1  synchronous active-high reset
i_mem_read  input  1  icache line read request
i_mem_addr  input  28  icache line address
i_mem_rdata  output  128  line data to icache
i_mem_ready  output  1  transaction-done pulse to icache
d_mem_read  input  1  dcache line read request
d_mem_write  input  1  dcache line write request
d_mem_addr  input  28  dcache line address
d_mem_wdata  input  128  dcache write line
d_mem_rdata  output  128  line data to dcache
d_mem_ready  output  1  transaction-done pulse to dcache
mem_read  output  1  read request to memory
mem_write  output  1  write request to memory
mem_addr  output  28  line address to memory
mem_wdata  output  128  write line to memory
mem_rdata  input  128  line data from memory
mem_ready  input  1  memory done pulse
arb_timeout  output  1  sticky: a transaction hit TIMEOUT
i_txn_cnt  output  CNT_W  completed icache transactions
d_txn_cnt  output  CNT_W  completed dcache transactions

Behaviour:
- Reset is synchronous on proc_reset.
  - All outputs reset to 0 and the FSM returns to IDLE.
  - last_grant resets to D, so the icache wins the first contention.
  - Counters, arb_timeout and the watchdog clear.
  - Reset mid-transaction abandons it; no ready pulse is produced.
- States:
  - IDLE: no grant; mem_read = mem_write = 0.
    - Only i requesting -> GNT_I.
    - Only d requesting (read or write) -> GNT_D.
    - Both requesting: grant the client that is not last_grant.
    - Neither -> stay in IDLE.
    - Grant takes effect the cycle after sampling: request at cycle t, memory sees it at t+1.
  - GNT_I: mem_read = i_mem_read, mem_write = 0, mem_addr = i_mem_addr, mem_wdata = 0.
  - GNT_D: mem_addr = d_mem_addr, mem_wdata = d_mem_wdata, mem_write = d_mem_write.
    - mem_read = d_mem_read & ~d_mem_write: write wins if both are asserted.
  - Leaving GNT_x:
    - On mem_ready: last_grant <= x, x_txn_cnt increments (wraps modulo 2^CNT_W), go to REL.
    - Granted client drops its request before mem_ready (abort): go to REL, no count.
    - Watchdog reaches TIMEOUT-1 with no mem_ready: set arb_timeout, go to REL, no ready pulse to the client.
  - REL: one cycle with mem_read = mem_write = 0 (guaranteed deassert gap); then IDLE.
    - Back-to-back transactions are therefore spaced by at least REL + IDLE.
- Ready and data routing:
  - i_mem_ready = mem_ready & (state == GNT_I); d_mem_ready likewise for GNT_D. Purely combinational, same cycle.
  - mem_ready outside GNT states is ignored.
  - mem_rdata is broadcast unchanged to both i_mem_rdata and d_mem_rdata.
- Watchdog: counts cycles in GNT_x; clears on entering GNT_x.
- arb_timeout clears only on reset.
- The un-granted client's request is held off; it receives no ready until granted.

Test Plan:
- Reset, then i_mem_read = 1 with addr 0x0000010 at cycle 2.
  - mem_read = 1 with mem_addr 0x0000010 from cycle 3.
  - mem_ready at cycle 6 -> i_mem_ready pulses at cycle 6, i_txn_cnt = 1, mem_read = 0 at cycle 7.
- Both clients request in the same IDLE cycle, repeatedly for 4 transactions.
  - Grants go I, D, I, D.
  - The dcache write presents d_mem_wdata = 0xDEADBEEF_..._01 on mem_wdata with mem_write = 1.
- dcache asserts read and write together -> mem_write = 1, mem_read = 0.
- TIMEOUT = 8, mem_ready never pulses.
  - arb_timeout = 1 after the 8th GNT cycle; FSM passes through REL to IDLE.
  - No d_mem_ready pulse; d_txn_cnt stays 0.
- proc_reset asserted mid-GNT_D.
  - Next cycle: mem_read = mem_write = 0, counters = 0, and subsequent contention grants I first.
- A stray mem_ready pulse in IDLE leaves both client ready outputs at 0 and both counts unchanged.
